// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
// Request size encoding, FSM state names and the store byte-lane mask.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_BAD = 2'b11} dmem_size_e;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} dmem_state_e;

  function automatic logic [3:0] lane_mask(input dmem_size_e size, input logic [1:0] offset);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << offset;
      SZ_H:    lane_mask = 4'b0011 << offset;
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: picks the byte/half lane addressed by offset out of a
// 32-bit memory word and sign- or zero-extends it to 32 bits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = word[{offset, 3'b000} +: 8];
    sel_h = offset[1] ? word[31:16] : word[15:0];
    rdata = word;
    case (dmem_size_e'(size))
      SZ_B:    rdata = is_unsigned ? {24'b0, sel_b} : {{24{sel_b[7]}}, sel_b};
      SZ_H:    rdata = is_unsigned ? {16'b0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU MEM-stage data port: one request per
// handshake, byte-lane stores, aligned extended loads, fixed response latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          accept;
  logic          in_err;
  logic          enter_resp;
  logic          do_write;

  logic          lat_we;
  logic          lat_uns;
  logic          lat_err;
  logic [AW+1:0] lat_addr;
  logic [1:0]    lat_size;
  logic [31:0]   lat_wdata;

  logic          cur_we;
  logic          cur_uns;
  logic          cur_err;
  logic [AW+1:0] cur_addr;
  logic [1:0]    cur_size;
  logic [31:0]   cur_wdata;

  logic [AW-1:0] idx;
  logic [3:0]    wmask;
  logic [31:0]   wdata_rep;
  logic [31:0]   rd_word;
  logic [31:0]   load_data;

  logic [31:0]   mem [DEPTH];

  assign accept    = req_valid & req_ready;
  assign req_ready = (state != S_BUSY);
  assign stall     = (state == S_BUSY);

  always_comb begin
    in_err = 1'b0;
    case (dmem_size_e'(req_size))
      SZ_H:    in_err = req_addr[0];
      SZ_W:    in_err = |req_addr[1:0];
      SZ_BAD:  in_err = 1'b1;
      default: in_err = 1'b0;
    endcase
    if (req_addr[31:2] >= 30'(DEPTH)) in_err = 1'b1;
  end

  // With single-cycle latency the access happens on the accept edge itself,
  // so the live request is used; otherwise the latched copy is.
  always_comb begin
    if (LATENCY == 1) begin
      cur_we    = req_we;
      cur_uns   = req_unsigned;
      cur_err   = in_err;
      cur_addr  = req_addr[AW+1:0];
      cur_size  = req_size;
      cur_wdata = req_wdata;
      enter_resp = accept;
    end else begin
      cur_we    = lat_we;
      cur_uns   = lat_uns;
      cur_err   = lat_err;
      cur_addr  = lat_addr;
      cur_size  = lat_size;
      cur_wdata = lat_wdata;
      enter_resp = (state == S_BUSY) && (cnt == 4'd1);
    end
  end

  assign idx      = cur_addr[AW+1:2];
  assign wmask    = lane_mask(dmem_size_e'(cur_size), cur_addr[1:0]);
  assign do_write = enter_resp & cur_we & ~cur_err & ~rst;
  assign rd_word  = mem[idx];

  always_comb begin
    case (dmem_size_e'(cur_size))
      SZ_B:    wdata_rep = {4{cur_wdata[7:0]}};
      SZ_H:    wdata_rep = {2{cur_wdata[15:0]}};
      default: wdata_rep = cur_wdata;
    endcase
  end

  dmem_load_align u_align (
    .word        (rd_word),
    .offset      (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .rdata       (load_data)
  );

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // Response registers are zero except in the single cycle after entering RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= 2'b00;
      lat_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      rsp_valid <= enter_resp;
      rsp_err   <= enter_resp & cur_err;
      rsp_rdata <= (enter_resp & ~cur_we & ~cur_err) ? load_data : 32'd0;
      case (state)
        S_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        default: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_err   <= in_err;
            lat_addr  <= req_addr[AW+1:0];
            lat_size  <= req_size;
            lat_wdata <= req_wdata;
            if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              state <= S_BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=1 and a LATENCY=4 responder against a
// byte-addressed reference model of the memory and load/store rules.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid1 = 1'b0;
  logic        req_valid4 = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'd0;

  logic        req_ready1, rsp_valid1, rsp_err1, stall1;
  logic [31:0] rsp_rdata1;
  logic        req_ready4, rsp_valid4, rsp_err4, stall4;
  logic [31:0] rsp_rdata4;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .stall(stall1)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid4),
    .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .stall(stall4)
  );

  // Reference: a request touches 2**size bytes starting at addr in a little-endian memory.
  function automatic void model_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                   input logic uns, input logic [31:0] wdata,
                                   output logic [31:0] exp_rdata, output logic exp_err);
    int nbytes;
    int off;
    logic [31:0] w;
    logic [31:0] mask;
    logic [31:0] val;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= DEPTH);
    exp_rdata = 32'd0;
    if (exp_err) return;
    nbytes = 1 << size;
    off    = int'(addr % 4);
    w      = model_mem[addr / 4];
    if (we) begin
      for (int k = 0; k < nbytes; k++) w[8*(off+k) +: 8] = wdata[8*k +: 8];
      model_mem[addr / 4] = w;
    end else begin
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      val  = (w >> (8 * off)) & mask;
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
      exp_rdata = val;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // LATENCY=1 request: driven at a negedge, response checked at the following negedge.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    logic [31:0] er;
    logic ee;
    model_op(we, addr, size, uns, wdata, er, ee);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("%s.valid", tag), 32'(rsp_valid1), 32'd1);
    checkOutput($sformatf("%s.rdata", tag), rsp_rdata1, er);
    checkOutput($sformatf("%s.err", tag), 32'(rsp_err1), 32'(ee));
    checkOutput($sformatf("%s.stall", tag), 32'(stall1), 32'd0);
  endtask

  task automatic issue4(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] er, output logic ee);
    model_op(we, addr, size, uns, wdata, er, ee);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
  endtask

  task automatic expect4(input string tag, input logic [31:0] er, input logic ee);
    for (int k = 1; k < 4; k++) begin
      checkOutput($sformatf("%s.c%0d.ready", tag, k), 32'(req_ready4), 32'd0);
      checkOutput($sformatf("%s.c%0d.stall", tag, k), 32'(stall4), 32'd1);
      checkOutput($sformatf("%s.c%0d.valid", tag, k), 32'(rsp_valid4), 32'd0);
      @(negedge clk);
    end
    checkOutput($sformatf("%s.c4.valid", tag), 32'(rsp_valid4), 32'd1);
    checkOutput($sformatf("%s.c4.ready", tag), 32'(req_ready4), 32'd1);
    checkOutput($sformatf("%s.c4.stall", tag), 32'(stall4), 32'd0);
    checkOutput($sformatf("%s.c4.rdata", tag), rsp_rdata4, er);
    checkOutput($sformatf("%s.c4.err", tag), 32'(rsp_err4), 32'(ee));
  endtask

  initial begin
    logic [31:0] er;
    logic ee;
    logic rw;
    logic ru;
    logic [1:0] rs;
    logic [31:0] ra;

    // Reset state
    #12;
    checkOutput("rst.ready1", 32'(req_ready1), 32'd1);
    checkOutput("rst.valid1", 32'(rsp_valid1), 32'd0);
    checkOutput("rst.rdata1", rsp_rdata1, 32'd0);
    checkOutput("rst.err1", 32'(rsp_err1), 32'd0);
    checkOutput("rst.stall4", 32'(stall4), 32'd0);
    checkOutput("rst.ready4", 32'(req_ready4), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back store/load with single-cycle latency
    applyStimulus("t1.sw", 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    applyStimulus("t1.lw", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);

    // Load extension
    applyStimulus("t2.sw", 1'b1, 32'h20, 2'd2, 1'b0, 32'h80FF7F01);
    applyStimulus("t2.lb", 1'b0, 32'h23, 2'd0, 1'b0, 32'h0);
    applyStimulus("t2.lbu", 1'b0, 32'h23, 2'd0, 1'b1, 32'h0);
    applyStimulus("t2.lh", 1'b0, 32'h22, 2'd1, 1'b0, 32'h0);
    applyStimulus("t2.lhu", 1'b0, 32'h20, 2'd1, 1'b1, 32'h0);
    applyStimulus("t2.lbs1", 1'b0, 32'h21, 2'd0, 1'b0, 32'h0);

    // Sub-word stores, upper wdata bits must be ignored
    applyStimulus("t3.sw", 1'b1, 32'h30, 2'd2, 1'b0, 32'h11223344);
    applyStimulus("t3.sb", 1'b1, 32'h31, 2'd0, 1'b0, 32'h987654AB);
    applyStimulus("t3.lw1", 1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
    applyStimulus("t3.sh", 1'b1, 32'h32, 2'd1, 1'b0, 32'h5555BEEF);
    applyStimulus("t3.lw2", 1'b0, 32'h30, 2'd2, 1'b0, 32'h0);

    // Error requests leave memory alone
    applyStimulus("t4.sw40", 1'b1, 32'h40, 2'd2, 1'b0, 32'hA5A5_0F0F);
    applyStimulus("t4.sw44", 1'b1, 32'h44, 2'd2, 1'b0, 32'h0102_0304);
    applyStimulus("t4.lw41", 1'b0, 32'h41, 2'd2, 1'b0, 32'h0);
    applyStimulus("t4.lh43", 1'b0, 32'h43, 2'd1, 1'b0, 32'h0);
    applyStimulus("t4.bad", 1'b0, 32'h40, 2'd3, 1'b0, 32'h0);
    applyStimulus("t4.oor", 1'b0, DEPTH * 4, 2'd2, 1'b0, 32'h0);
    applyStimulus("t4.swmis", 1'b1, 32'h42, 2'd2, 1'b0, 32'hFFFF_FFFF);
    applyStimulus("t4.sbbad", 1'b1, 32'h44, 2'd3, 1'b0, 32'hFFFF_FFFF);
    applyStimulus("t4.shmis", 1'b1, 32'h45, 2'd1, 1'b0, 32'hFFFF_FFFF);
    applyStimulus("t4.chk40", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
    applyStimulus("t4.chk44", 1'b0, 32'h44, 2'd2, 1'b0, 32'h0);

    // Randomized traffic over a filled window plus some out-of-range addresses
    for (int i = 0; i < 16; i++) applyStimulus("fill", 1'b1, 32'h100 + 32'(4 * i), 2'd2, 1'b0, $urandom);
    for (int i = 0; i < 60; i++) begin
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 63))
                                       : 32'h100 + 32'($urandom_range(0, 63));
      applyStimulus($sformatf("rnd%0d", i), rw, ra, rs, ru, $urandom);
    end
    req_valid1 = 1'b0;
    @(negedge clk);
    checkOutput("idle.valid1", 32'(rsp_valid1), 32'd0);

    // LATENCY=4 timing with a back-to-back accept in the response cycle
    issue4(1'b1, 32'h50, 2'd2, 1'b0, 32'h12345678, er, ee);
    expect4("t5.sw", er, ee);
    issue4(1'b0, 32'h50, 2'd2, 1'b0, 32'h0, er, ee);
    expect4("t5.lw", er, ee);
    @(negedge clk);
    checkOutput("t5.after.valid", 32'(rsp_valid4), 32'd0);
    checkOutput("t5.after.rdata", rsp_rdata4, 32'd0);

    // Reset during BUSY aborts the store and suppresses the response
    req_we = 1'b1; req_addr = 32'h50; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
    req_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t6.novalid%0d", k), 32'(rsp_valid4), 32'd0);
      @(negedge clk);
    end
    checkOutput("t6.ready", 32'(req_ready4), 32'd1);
    issue4(1'b0, 32'h50, 2'd2, 1'b0, 32'h0, er, ee);
    expect4("t6.lw", er, ee);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
